// File: rtl/dr_l2_responder.sv
// Directory-side endpoint of the L2<->directory protocol, backed by a small line store.
// Define DR_L2RESP_STATS_EN to build the saturating request/displacement/snoop-ack counters.
module dr_l2_responder #(
  parameter int QDEPTH  = 4,
  parameter int NLINES  = 16,
  parameter int LATENCY = 3,
  parameter int DIR_ID  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         l2todr_req_valid,
  output logic         l2todr_req_retry,
  input  logic [4:0]   l2todr_req_nid,
  input  logic [5:0]   l2todr_req_l2id,
  input  logic [2:0]   l2todr_req_cmd,
  input  logic [49:0]  l2todr_req_paddr,
  output logic         drtol2_snack_valid,
  input  logic         drtol2_snack_retry,
  output logic [4:0]   drtol2_snack_nid,
  output logic [5:0]   drtol2_snack_l2id,
  output logic [5:0]   drtol2_snack_drid,
  output logic [1:0]   drtol2_snack_directory_id,
  output logic [4:0]   drtol2_snack_snack,
  output logic [511:0] drtol2_snack_line,
  output logic [49:0]  drtol2_snack_paddr,
  input  logic         l2todr_disp_valid,
  output logic         l2todr_disp_retry,
  input  logic [4:0]   l2todr_disp_nid,
  input  logic [5:0]   l2todr_disp_l2id,
  input  logic [5:0]   l2todr_disp_drid,
  input  logic [63:0]  l2todr_disp_mask,
  input  logic [2:0]   l2todr_disp_dcmd,
  input  logic [511:0] l2todr_disp_line,
  input  logic [49:0]  l2todr_disp_paddr,
  output logic         drtol2_dack_valid,
  input  logic         drtol2_dack_retry,
  output logic [4:0]   drtol2_dack_nid,
  output logic [5:0]   drtol2_dack_l2id,
  input  logic         l2todr_snoop_ack_valid,
  output logic         l2todr_snoop_ack_retry,
  input  logic [5:0]   l2todr_snoop_ack_l2id,
  input  logic [1:0]   l2todr_snoop_ack_directory_id,
  output logic [15:0]  stats_nreq,
  output logic [15:0]  stats_ndisp,
  output logic [15:0]  stats_nsack
);
  localparam int IDXW = $clog2(NLINES);
  localparam int QAW  = $clog2(QDEPTH);
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = (LATENCY > 0) ? CNTW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [QAW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [QAW:0]           count_q, count_d;
  logic [63:0]            q_mem_q [QDEPTH];
  logic [NLINES-1:0][511:0] mem_q;
  logic [5:0]             drid_q;
  logic [4:0]             sn_nid_q;
  logic [5:0]             sn_l2id_q;
  logic [2:0]             sn_cmd_q;
  logic [49:0]            sn_paddr_q;
  logic [511:0]           sn_line_q;
  logic                   dack_valid_q;
  logic [4:0]             dack_nid_q;
  logic [5:0]             dack_l2id_q;
  logic [511:0]           wline_d;
  logic                   push, pop, snack_hs, disp_acc;
  logic [63:0]            head;
  logic [IDXW-1:0]        head_idx, disp_idx;

  assign l2todr_req_retry  = (count_q == (QAW+1)'(QDEPTH));
  assign push              = l2todr_req_valid && !l2todr_req_retry;
  assign head              = q_mem_q[rd_ptr_q];
  assign head_idx          = head[6 +: IDXW];
  assign disp_idx          = l2todr_disp_paddr[6 +: IDXW];
  assign l2todr_disp_retry = dack_valid_q;
  assign disp_acc          = l2todr_disp_valid && !dack_valid_q;
  assign l2todr_snoop_ack_retry = 1'b0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    snack_hs = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = (LATENCY == 0) ? S_SEND : S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) state_d = S_SEND;
              else cnt_d = cnt_q - CNTW'(1);
      S_SEND: if (!drtol2_snack_retry) begin
        snack_hs = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (QAW+1)'(1);
      2'b01:   count_d = count_q - (QAW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Byte-merge of the displaced line into the addressed store entry.
  always_comb begin
    wline_d = mem_q[disp_idx];
    for (int b = 0; b < 64; b++)
      if (l2todr_disp_mask[b]) wline_d[8*b +: 8] = l2todr_disp_line[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (push) q_mem_q[wr_ptr_q] <= {l2todr_req_nid, l2todr_req_l2id, l2todr_req_cmd, l2todr_req_paddr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drid_q       <= '0;
      sn_nid_q     <= '0;
      sn_l2id_q    <= '0;
      sn_cmd_q     <= '0;
      sn_paddr_q   <= '0;
      sn_line_q    <= '0;
      dack_valid_q <= 1'b0;
      dack_nid_q   <= '0;
      dack_l2id_q  <= '0;
      mem_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + QAW'(1);
      // The store is read before this edge's displacement write lands.
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + QAW'(1);
        sn_nid_q   <= head[63:59];
        sn_l2id_q  <= head[58:53];
        sn_cmd_q   <= head[52:50];
        sn_paddr_q <= head[49:0];
        sn_line_q  <= mem_q[head_idx];
      end
      if (snack_hs) drid_q <= drid_q + 6'd1;
      if (disp_acc) begin
        mem_q[disp_idx] <= wline_d;
        dack_valid_q    <= 1'b1;
        dack_nid_q      <= l2todr_disp_nid;
        dack_l2id_q     <= l2todr_disp_l2id;
      end else if (dack_valid_q && !drtol2_dack_retry) begin
        dack_valid_q <= 1'b0;
      end
    end
  end

  assign drtol2_snack_valid        = (state_q == S_SEND);
  assign drtol2_snack_nid          = sn_nid_q;
  assign drtol2_snack_l2id         = sn_l2id_q;
  assign drtol2_snack_drid         = drid_q;
  assign drtol2_snack_directory_id = 2'(DIR_ID);
  assign drtol2_snack_snack        = {2'b01, sn_cmd_q};
  assign drtol2_snack_line         = sn_line_q;
  assign drtol2_snack_paddr        = sn_paddr_q;
  assign drtol2_dack_valid         = dack_valid_q;
  assign drtol2_dack_nid           = dack_nid_q;
  assign drtol2_dack_l2id          = dack_l2id_q;

`ifdef DR_L2RESP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] nreq_q, ndisp_q, nsack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nreq_q  <= '0;
      ndisp_q <= '0;
      nsack_q <= '0;
    end else begin
      if (push)                   nreq_q  <= sat_inc(nreq_q);
      if (disp_acc)               ndisp_q <= sat_inc(ndisp_q);
      if (l2todr_snoop_ack_valid) nsack_q <= sat_inc(nsack_q);
    end
  end

  assign stats_nreq  = nreq_q;
  assign stats_ndisp = ndisp_q;
  assign stats_nsack = nsack_q;
`else
  assign stats_nreq  = '0;
  assign stats_ndisp = '0;
  assign stats_nsack = '0;
`endif

  // Protocol fields this stand-in accepts but has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{l2todr_disp_drid, l2todr_disp_dcmd, l2todr_disp_paddr,
                           l2todr_snoop_ack_l2id, l2todr_snoop_ack_directory_id,
                           l2todr_snoop_ack_valid};
endmodule

// File: tb/tb_dr_l2_responder.sv
// Bench for dr_l2_responder: transaction-level model of queue, line store and responder
// timing, compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_dr_l2_responder;
  localparam int QDEPTH = 4, NLINES = 16, LATENCY = 3, DIR_ID = 2;
  localparam int IDXW = $clog2(NLINES);
  localparam int NR = 3000;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 0, req_retry; logic [4:0] req_nid = 0; logic [5:0] req_l2id = 0;
  logic [2:0] req_cmd = 0; logic [49:0] req_paddr = 0;
  logic snack_valid, snack_retry = 0; logic [4:0] snack_nid; logic [5:0] snack_l2id, snack_drid;
  logic [1:0] snack_dirid; logic [4:0] snack_snack; logic [511:0] snack_line; logic [49:0] snack_paddr;
  logic disp_valid = 0, disp_retry; logic [4:0] disp_nid = 0; logic [5:0] disp_l2id = 0, disp_drid = 0;
  logic [63:0] disp_mask = 0; logic [2:0] disp_dcmd = 0; logic [511:0] disp_line = 0; logic [49:0] disp_paddr = 0;
  logic dack_valid, dack_retry = 0; logic [4:0] dack_nid; logic [5:0] dack_l2id;
  logic sack_valid = 0, sack_retry; logic [5:0] sack_l2id = 0; logic [1:0] sack_dirid = 0;
  logic [15:0] st_nreq, st_ndisp, st_nsack;

  always #5 clk = ~clk;

  dr_l2_responder #(.QDEPTH(QDEPTH), .NLINES(NLINES), .LATENCY(LATENCY), .DIR_ID(DIR_ID)) dut (
    .clk(clk), .reset(reset),
    .l2todr_req_valid(req_valid), .l2todr_req_retry(req_retry), .l2todr_req_nid(req_nid),
    .l2todr_req_l2id(req_l2id), .l2todr_req_cmd(req_cmd), .l2todr_req_paddr(req_paddr),
    .drtol2_snack_valid(snack_valid), .drtol2_snack_retry(snack_retry), .drtol2_snack_nid(snack_nid),
    .drtol2_snack_l2id(snack_l2id), .drtol2_snack_drid(snack_drid), .drtol2_snack_directory_id(snack_dirid),
    .drtol2_snack_snack(snack_snack), .drtol2_snack_line(snack_line), .drtol2_snack_paddr(snack_paddr),
    .l2todr_disp_valid(disp_valid), .l2todr_disp_retry(disp_retry), .l2todr_disp_nid(disp_nid),
    .l2todr_disp_l2id(disp_l2id), .l2todr_disp_drid(disp_drid), .l2todr_disp_mask(disp_mask),
    .l2todr_disp_dcmd(disp_dcmd), .l2todr_disp_line(disp_line), .l2todr_disp_paddr(disp_paddr),
    .drtol2_dack_valid(dack_valid), .drtol2_dack_retry(dack_retry), .drtol2_dack_nid(dack_nid),
    .drtol2_dack_l2id(dack_l2id),
    .l2todr_snoop_ack_valid(sack_valid), .l2todr_snoop_ack_retry(sack_retry),
    .l2todr_snoop_ack_l2id(sack_l2id), .l2todr_snoop_ack_directory_id(sack_dirid),
    .stats_nreq(st_nreq), .stats_ndisp(st_ndisp), .stats_nsack(st_nsack)
  );

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: requests wait in order; the responder takes the oldest one as soon as it
  // is free, snapshots the line, presents it LATENCY cycles after the take, and is free again
  // after the snack handshake.
  typedef struct packed { logic [4:0] nid; logic [5:0] l2id; logic [2:0] cmd; logic [49:0] paddr; } req_t;
  req_t rq[$];
  req_t o;
  logic [511:0] mem [NLINES];
  logic [511:0] o_line;
  bit out_act = 0, dack_p = 0;
  int out_vedge = 0, drid_m = 0, m_nreq = 0, m_ndisp = 0, m_nsack = 0;
  logic [4:0] dk_nid; logic [5:0] dk_l2id;
  logic [5:0] hs_drid[$];

  always @(negedge clk) begin
    bit exp_rr, exp_sv, sn_hs, dk_hs, rq_acc, dp_acc;
    logic [15:0] e_nreq, e_ndisp, e_nsack;
    if (reset) begin
      rq.delete(); hs_drid.delete();
      out_act = 0; dack_p = 0; drid_m = 0; m_nreq = 0; m_ndisp = 0; m_nsack = 0;
      for (int i = 0; i < NLINES; i++) mem[i] = '0;
    end
    exp_rr = (rq.size() == QDEPTH);
    exp_sv = out_act && (cyc >= out_vedge);
    chk("req_retry", 64'(req_retry), 64'(exp_rr));
    chk("disp_retry", 64'(disp_retry), 64'(dack_p));
    chk("snoop_ack_retry", 64'(sack_retry), 64'(0));
    chk("snack_valid", 64'(snack_valid), 64'(exp_sv));
    chk("dack_valid", 64'(dack_valid), 64'(dack_p));
    if (exp_sv) begin
      chk("snack_nid", 64'(snack_nid), 64'(o.nid));
      chk("snack_l2id", 64'(snack_l2id), 64'(o.l2id));
      chk("snack_drid", 64'(snack_drid), 64'(drid_m));
      chk("snack_dirid", 64'(snack_dirid), 64'(DIR_ID));
      chk("snack_snack", 64'(snack_snack), 64'({2'b01, o.cmd}));
      chk("snack_paddr", 64'(snack_paddr), 64'(o.paddr));
      chkw("snack_line", snack_line, o_line);
    end
    if (dack_p) begin
      chk("dack_nid", 64'(dack_nid), 64'(dk_nid));
      chk("dack_l2id", 64'(dack_l2id), 64'(dk_l2id));
    end
`ifdef DR_L2RESP_STATS_EN
    e_nreq = 16'(m_nreq); e_ndisp = 16'(m_ndisp); e_nsack = 16'(m_nsack);
`else
    e_nreq = 0; e_ndisp = 0; e_nsack = 0;
`endif
    chk("stats_nreq", 64'(st_nreq), 64'(e_nreq));
    chk("stats_ndisp", 64'(st_ndisp), 64'(e_ndisp));
    chk("stats_nsack", 64'(st_nsack), 64'(e_nsack));
    if (!reset) begin
      sn_hs  = exp_sv && !snack_retry;
      dk_hs  = dack_p && !dack_retry;
      rq_acc = req_valid && !exp_rr;
      dp_acc = disp_valid && !dack_p;
      if (!out_act && rq.size() > 0) begin
        o = rq.pop_front();
        o_line = mem[o.paddr[6 +: IDXW]];
        out_act = 1;
        out_vedge = cyc + 1 + LATENCY;
      end else if (sn_hs) begin
        hs_drid.push_back(snack_drid);
        out_act = 0;
        drid_m = (drid_m + 1) % 64;
      end
      if (rq_acc) rq.push_back('{req_nid, req_l2id, req_cmd, req_paddr});
      if (dp_acc) begin
        for (int b = 0; b < 64; b++)
          if (disp_mask[b]) mem[disp_paddr[6 +: IDXW]][8*b +: 8] = disp_line[8*b +: 8];
        dack_p = 1; dk_nid = disp_nid; dk_l2id = disp_l2id;
      end else if (dk_hs) dack_p = 0;
      if (rq_acc && m_nreq < 65535) m_nreq++;
      if (dp_acc && m_ndisp < 65535) m_ndisp++;
      if (sack_valid && m_nsack < 65535) m_nsack++;
    end
  end

  task automatic drive_req(input logic [4:0] n, input logic [5:0] l, input logic [2:0] c,
                           input logic [49:0] p, output int acc);
    req_nid = n; req_l2id = l; req_cmd = c; req_paddr = p; req_valid = 1;
    acc = -1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      @(negedge clk);
      if (!req_retry) begin @(posedge clk); #1; acc = cyc; end
      else begin @(posedge clk); #1; end
    end
    req_valid = 0;
    chk("req_accept_in_time", 64'(acc >= 0), 64'(1));
  endtask

  task automatic drive_disp(input logic [4:0] n, input logic [5:0] l, input logic [63:0] m,
                            input logic [511:0] ln, input logic [49:0] p, output int acc);
    disp_nid = n; disp_l2id = l; disp_mask = m; disp_line = ln; disp_paddr = p; disp_valid = 1;
    acc = -1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      @(negedge clk);
      if (!disp_retry) begin @(posedge clk); #1; acc = cyc; end
      else begin @(posedge clk); #1; end
    end
    disp_valid = 0;
    chk("disp_accept_in_time", 64'(acc >= 0), 64'(1));
  endtask

  task automatic wait_snack(output int e);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = snack_valid;
    end
    e = cyc;
    chk("snack_in_time", 64'(found), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a, e;
    logic [511:0] ln;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_snack_valid", 64'(snack_valid), 64'(0));
    chk("rst_req_retry", 64'(req_retry), 64'(0));
    chk("rst_dack_valid", 64'(dack_valid), 64'(0));
    chk("rst_drid", 64'(snack_drid), 64'(0));
    chk("rst_stats", 64'({st_nreq, st_ndisp, st_nsack}), 64'(0));
    idle(1);

    // First request: visible four edges after its accept edge.
    drive_req(5'd3, 6'd5, 3'd1, 50'h40, a);
    wait_snack(e);
    chk("t1_latency", 64'(e - a), 64'(4));
    chk("t1_snack", 64'(snack_snack), 64'(5'b01001));
    chk("t1_drid", 64'(snack_drid), 64'(0));
    chk("t1_nid_l2id", 64'({snack_nid, snack_l2id}), 64'({5'd3, 6'd5}));
    chkw("t1_line", snack_line, 512'd0);
    idle(1);

    // Masked displacement then read-back of the same line.
    ln = {64{8'h55}}; ln[7:0] = 8'hAB;
    drive_disp(5'd7, 6'd9, 64'h1, ln, 50'h40, a);
    @(negedge clk);
    chk("t2_dack_valid", 64'(dack_valid), 64'(1));
    chk("t2_dack_ids", 64'({dack_nid, dack_l2id}), 64'({5'd7, 6'd9}));
    idle(1);
    drive_req(5'd0, 6'd1, 3'd2, 50'h40, a);
    wait_snack(e);
    chk("t2_byte0", 64'(snack_line[7:0]), 64'(8'hAB));
    chkw("t2_upper", snack_line >> 8, 512'd0);
    idle(1);

    // Queue fill while snacks are back-pressured.
    snack_retry = 1;
    for (int k = 0; k < 5; k++) drive_req(5'(k), 6'(k), 3'd3, 50'(128 + 64 * k), a);
    @(negedge clk);
    chk("t3_full", 64'(req_retry), 64'(1));
    @(posedge clk); #1;
    req_nid = 5'd20; req_l2id = 6'd21; req_cmd = 3'd4; req_paddr = 50'h1c0; req_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold", 64'(req_retry), 64'(1));
    end
    @(posedge clk); #1 snack_retry = 0;
    drive_req(5'd20, 6'd21, 3'd4, 50'h1c0, a);
    idle(40);

    // drid wrap across 65 snacks.
    do_reset();
    for (int k = 0; k < 65; k++) drive_req(5'($urandom()), 6'(k), 3'($urandom()), 50'(64 * k), a);
    for (int i = 0; i < 600 && hs_drid.size() < 65; i++) @(posedge clk);
    #1;
    chk("t4_snacks_done", 64'(hs_drid.size() >= 65), 64'(1));
    if (hs_drid.size() >= 65) begin
      chk("t4_drid_first", 64'(hs_drid[0]), 64'(0));
      chk("t4_drid_63", 64'(hs_drid[63]), 64'(63));
      chk("t4_drid_wrap", 64'(hs_drid[64]), 64'(0));
    end

    // Single outstanding dack.
    dack_retry = 1;
    drive_disp(5'd1, 6'd2, 64'hF0, {16{32'hDEADBEEF}}, 50'h100, a);
    disp_nid = 5'd4; disp_l2id = 6'd6; disp_mask = 64'h0F; disp_paddr = 50'h100; disp_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_disp_retry", 64'(disp_retry), 64'(1));
    end
    @(posedge clk); #1 dack_retry = 0;
    drive_disp(5'd4, 6'd6, 64'h0F, {16{32'hDEADBEEF}}, 50'h100, a);
    idle(3);

    // Stats and reset in the middle of a wait.
    do_reset();
    drive_req(5'd1, 6'd1, 3'd0, 50'h0, a);
    drive_req(5'd2, 6'd2, 3'd0, 50'h40, a);
    drive_disp(5'd3, 6'd3, 64'h3, {16{32'h12345678}}, 50'h80, a);
    repeat (3) begin sack_valid = 1; @(posedge clk); #1; end
    sack_valid = 0;
    idle(15);
    @(negedge clk);
`ifdef DR_L2RESP_STATS_EN
    chk("t6_stats", 64'({st_nreq, st_ndisp, st_nsack}), 64'({16'd2, 16'd1, 16'd3}));
`else
    chk("t6_stats", 64'({st_nreq, st_ndisp, st_nsack}), 64'(0));
`endif
    @(posedge clk); #1;
    drive_req(5'd9, 6'd9, 3'd7, 50'h40, a);
    idle(2);
    reset = 1;
    @(negedge clk);
    chk("t6_rst_snack_valid", 64'(snack_valid), 64'(0));
    chk("t6_rst_stats", 64'({st_nreq, st_ndisp, st_nsack}), 64'(0));
    @(posedge clk); #1 reset = 0;

    // Randomized traffic on all channels.
    fork
      begin
        bit tk;
        for (int c = 0; c < NR; c++) begin
          @(negedge clk); tk = req_valid && !req_retry;
          @(posedge clk); #1;
          if (!req_valid || tk) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_nid = 5'($urandom()); req_l2id = 6'($urandom()); req_cmd = 3'($urandom());
            req_paddr = 50'({$urandom(), $urandom()});
            req_paddr[6 +: IDXW] = IDXW'($urandom_range(0, 3));
          end
        end
        req_valid = 0;
      end
      begin
        bit tk;
        for (int c = 0; c < NR; c++) begin
          @(negedge clk); tk = disp_valid && !disp_retry;
          @(posedge clk); #1;
          if (!disp_valid || tk) begin
            disp_valid = ($urandom_range(0, 3) == 0);
            disp_nid = 5'($urandom()); disp_l2id = 6'($urandom());
            disp_drid = 6'($urandom()); disp_dcmd = 3'($urandom());
            disp_mask = 64'({$urandom(), $urandom()}) & 64'({$urandom(), $urandom()});
            for (int k = 0; k < 16; k++) disp_line[32*k +: 32] = $urandom();
            disp_paddr = 50'({$urandom(), $urandom()});
            disp_paddr[6 +: IDXW] = IDXW'($urandom_range(0, 3));
          end
        end
        disp_valid = 0;
      end
      begin
        for (int c = 0; c < NR; c++) begin
          @(posedge clk); #1;
          sack_valid = ($urandom_range(0, 1) == 0);
          sack_l2id = 6'($urandom()); sack_dirid = 2'($urandom());
          snack_retry = ($urandom_range(0, 3) == 0);
          dack_retry = ($urandom_range(0, 3) == 0);
        end
        sack_valid = 0; snack_retry = 0; dack_retry = 0;
      end
    join
    idle(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
